// File: rtl/fp_op_sequencer.sv
// Command sequencer for the 32x32 operand memory and the external FP ALU.
// It reads two operands in one memory access, screens them for NaN, runs the
// ALU through a start/done handshake, and writes the result back to dst.
// All outputs except cmd_ready come from flops.
module fp_op_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src1,
  input  logic [ADDR_W-1:0] cmd_src2,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [OP_W-1:0]   cmd_op,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr1,
  output logic [ADDR_W-1:0] mem_rd_addr2,
  input  logic [DATA_W-1:0] mem_rd_data1,
  input  logic [DATA_W-1:0] mem_rd_data2,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  output logic [1:0]        rsp_err,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, EXEC, FINISH} state_t;

  localparam logic [DATA_W-1:0] QNAN     = 32'h7FC0_0000;
  localparam logic [1:0]        ERR_OK   = 2'b00;
  localparam logic [1:0]        ERR_NAN  = 2'b01;
  localparam logic [1:0]        ERR_TOUT = 2'b10;

  state_t            state, state_n;
  logic [ADDR_W-1:0] dst_q, dst_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              rd_en_n, wr_en_n, start_n, rsp_valid_n, busy_n;
  logic [ADDR_W-1:0] rd_addr1_n, rd_addr2_n, wr_addr_n;
  logic [DATA_W-1:0] wr_data_n, alu_a_n, alu_b_n;
  logic [OP_W-1:0]   alu_op_n;
  logic [1:0]        rsp_err_n;

  // A quiet or signalling NaN has an all-ones exponent and a nonzero mantissa.
  function automatic logic is_nan(input logic [DATA_W-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign cmd_ready = (state == IDLE) && !rst;

  // Next-state and next-output decode; every output flop is loaded from here.
  always_comb begin
    state_n     = state;
    dst_n       = dst_q;
    op_n        = op_q;
    cnt_n       = cnt;
    rd_en_n     = 1'b0;
    rd_addr1_n  = '0;
    rd_addr2_n  = '0;
    wr_en_n     = 1'b0;
    wr_addr_n   = '0;
    wr_data_n   = '0;
    start_n     = 1'b0;
    alu_op_n    = alu_op;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    rsp_valid_n = 1'b0;
    rsp_err_n   = ERR_OK;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_n    = READ;
          dst_n      = cmd_dst;
          op_n       = cmd_op;
          rd_en_n    = 1'b1;
          rd_addr1_n = cmd_src1;
          rd_addr2_n = cmd_src2;
        end
      end
      READ: begin
        state_n = LATCH;
      end
      LATCH: begin
        if (is_nan(mem_rd_data1) || is_nan(mem_rd_data2)) begin
          state_n     = FINISH;
          rsp_valid_n = 1'b1;
          rsp_err_n   = ERR_NAN;
          wr_en_n     = 1'b1;
          wr_addr_n   = dst_q;
          wr_data_n   = QNAN;
        end else begin
          state_n  = EXEC;
          start_n  = 1'b1;
          alu_a_n  = mem_rd_data1;
          alu_b_n  = mem_rd_data2;
          alu_op_n = op_q;
          cnt_n    = '0;
        end
      end
      EXEC: begin
        if (alu_done) begin
          state_n     = FINISH;
          rsp_valid_n = 1'b1;
          rsp_err_n   = ERR_OK;
          wr_en_n     = 1'b1;
          wr_addr_n   = dst_q;
          wr_data_n   = alu_result;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n     = FINISH;
          rsp_valid_n = 1'b1;
          rsp_err_n   = ERR_TOUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
        if (state_n == FINISH) begin
          alu_a_n  = '0;
          alu_b_n  = '0;
          alu_op_n = '0;
        end
      end
      FINISH: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, command latches and all registered outputs; reset wins everywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dst_q        <= '0;
      op_q         <= '0;
      cnt          <= '0;
      mem_rd_en    <= 1'b0;
      mem_rd_addr1 <= '0;
      mem_rd_addr2 <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
      alu_start    <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_err      <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      dst_q        <= dst_n;
      op_q         <= op_n;
      cnt          <= cnt_n;
      mem_rd_en    <= rd_en_n;
      mem_rd_addr1 <= rd_addr1_n;
      mem_rd_addr2 <= rd_addr2_n;
      mem_wr_en    <= wr_en_n;
      mem_wr_addr  <= wr_addr_n;
      mem_wr_data  <= wr_data_n;
      alu_start    <= start_n;
      alu_op       <= alu_op_n;
      alu_a        <= alu_a_n;
      alu_b        <= alu_b_n;
      rsp_valid    <= rsp_valid_n;
      rsp_err      <= rsp_err_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_fp_op_sequencer.sv
// Bench for fp_op_sequencer: operand memory and ALU models, a response
// scoreboard fed by the stimulus, and directed cycle-level checks.
module tb_fp_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_src1 = '0, cmd_src2 = '0, cmd_dst = '0;
  logic [2:0]  cmd_op = '0;
  logic        mem_rd_en, mem_wr_en;
  logic [4:0]  mem_rd_addr1, mem_rd_addr2, mem_wr_addr;
  logic [31:0] mem_rd_data1, mem_rd_data2, mem_wr_data;
  logic        alu_start, alu_done;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_err;

  logic [31:0] mem [32];
  logic        alu_comb_mode = 1'b0;
  logic        alu_slow_mode = 1'b0;
  logic        stray_done = 1'b0;
  logic [31:0] alu_res_val = '0;
  logic [3:0]  slow_cnt = '0;

  typedef struct {
    logic [1:0]  err;
    logic        wr_en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  fp_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst(cmd_dst), .cmd_op(cmd_op),
    .mem_rd_en(mem_rd_en), .mem_rd_addr1(mem_rd_addr1), .mem_rd_addr2(mem_rd_addr2),
    .mem_rd_data1(mem_rd_data1), .mem_rd_data2(mem_rd_data2),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Operand memory: registered dual read, single write.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) begin
      mem_rd_data1 <= mem[mem_rd_addr1];
      mem_rd_data2 <= mem[mem_rd_addr2];
    end
  end

  // Slow ALU timer: done is raised 10 cycles after the start pulse.
  always @(posedge clk) begin
    if (alu_start) slow_cnt <= 4'd10;
    else if (slow_cnt != 4'd0) slow_cnt <= slow_cnt - 4'd1;
  end

  assign alu_done = (alu_comb_mode & alu_start) |
                    (alu_slow_mode & (slow_cnt == 4'd1)) | stray_done;
  assign alu_result = alu_res_val;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every response pulse is matched against the queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      check_output("rd_wr_exclusive", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: got rsp_err=%b expected no response", rsp_err);
        end else begin
          e = exp_q.pop_front();
          check_output("rsp_err", {30'b0, rsp_err}, {30'b0, e.err});
          check_output("rsp_wr_en", {31'b0, mem_wr_en}, {31'b0, e.wr_en});
          if (e.wr_en) begin
            check_output("rsp_wr_addr", {27'b0, mem_wr_addr}, {27'b0, e.addr});
            check_output("rsp_wr_data", mem_wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] err, input logic wr_en,
                          input logic [4:0] addr, input logic [31:0] data);
    exp_t e;
    e.err = err; e.wr_en = wr_en; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for one edge.
  task automatic apply_stimulus(input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] d, input logic [2:0] op);
    int k;
    k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) check_output("ready_wait_timeout", 32'd0, 32'd1);
    cmd_src1 = s1; cmd_src2 = s2; cmd_dst = d; cmd_op = op;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no completion expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n, starts, stable, ready_seen;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[1] = 32'h7FC0_0001;
    mem[3] = 32'h3F80_0000;
    mem[4] = 32'h4000_0000;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("reset_cmd_ready_in_rst", {31'b0, cmd_ready}, 32'd0);
    check_output("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_output("reset_outputs",
                 {26'b0, mem_rd_en, mem_wr_en, alu_start, rsp_valid, rsp_err},
                 32'd0);

    // Normal operation with a combinational ALU
    alu_comb_mode = 1'b1; alu_res_val = 32'h4040_0000;
    push_exp(2'b00, 1'b1, 5'd5, 32'h4040_0000);
    apply_stimulus(5'd3, 5'd4, 5'd5, 3'd1);
    @(negedge clk);
    check_output("norm_c1_rd_en", {31'b0, mem_rd_en}, 32'd1);
    check_output("norm_c1_addr1", {27'b0, mem_rd_addr1}, 32'd3);
    check_output("norm_c1_addr2", {27'b0, mem_rd_addr2}, 32'd4);
    check_output("norm_c1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check_output("norm_c2_rd_en", {31'b0, mem_rd_en}, 32'd0);
    @(negedge clk);
    check_output("norm_c3_start", {31'b0, alu_start}, 32'd1);
    check_output("norm_c3_alu_a", alu_a, 32'h3F80_0000);
    check_output("norm_c3_alu_b", alu_b, 32'h4000_0000);
    check_output("norm_c3_alu_op", {29'b0, alu_op}, 32'd1);
    @(negedge clk);
    check_output("norm_c4_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    check_output("norm_c5_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_output("norm_mem5", mem[5], 32'h4040_0000);

    // NaN bypass: ALU never started, quiet NaN written in c3
    push_exp(2'b01, 1'b1, 5'd6, 32'h7FC0_0000);
    apply_stimulus(5'd1, 5'd2, 5'd6, 3'd0);
    starts = 0;
    @(negedge clk); starts += int'(alu_start);
    check_output("nan_c1_rd_en", {31'b0, mem_rd_en}, 32'd1);
    @(negedge clk); starts += int'(alu_start);
    @(negedge clk); starts += int'(alu_start);
    check_output("nan_c3_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk); starts += int'(alu_start);
    check_output("nan_c4_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_output("nan_no_start", starts, 32'd0);
    check_output("nan_mem6", mem[6], 32'h7FC0_0000);

    // Timeout: done never arrives
    alu_comb_mode = 1'b0;
    push_exp(2'b10, 1'b0, 5'd9, 32'h0);
    apply_stimulus(5'd3, 5'd4, 5'd9, 3'd2);
    repeat (2) @(negedge clk);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      n++;
    end
    check_output("tout_exec_cycles", n, 32'd64);
    check_output("tout_no_write", {31'b0, mem_wr_en}, 32'd0);
    @(negedge clk);
    check_output("tout_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check_output("tout_mem9", mem[9], 32'h0);

    // Slow ALU: done 10 cycles after start
    alu_slow_mode = 1'b1; alu_res_val = 32'h1234_5678;
    push_exp(2'b00, 1'b1, 5'd10, 32'h1234_5678);
    apply_stimulus(5'd4, 5'd3, 5'd10, 3'd5);
    repeat (2) @(negedge clk);
    n = 0; starts = 0; stable = 1;
    while (n < 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      starts += int'(alu_start);
      if (alu_a !== 32'h4000_0000 || alu_b !== 32'h3F80_0000 || alu_op !== 3'd5)
        stable = 0;
      n++;
    end
    check_output("slow_exec_cycles", n, 32'd11);
    check_output("slow_start_pulses", starts, 32'd1);
    check_output("slow_operands_stable", stable, 32'd1);
    @(negedge clk);
    check_output("slow_mem10", mem[10], 32'h1234_5678);
    alu_slow_mode = 1'b0;

    // Reset in the middle of EXEC, then a stray done
    apply_stimulus(5'd3, 5'd4, 5'd11, 3'd3);
    repeat (7) @(negedge clk);
    check_output("rst_mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_output("rst_mid_cmd_ready_in_rst", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    stray_done = 1'b1; alu_res_val = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("rst_mid_outputs",
                 {25'b0, busy, mem_rd_en, mem_wr_en, alu_start, rsp_valid, rsp_err},
                 32'd0);
    check_output("rst_mid_alu_a", alu_a, 32'h0);
    check_output("rst_mid_alu_b", alu_b, 32'h0);
    check_output("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_mid_idle_busy", {31'b0, busy}, 32'd0);
    check_output("rst_mid_mem11", mem[11], 32'h0);

    // Back-to-back: second command reads the first one's result
    alu_comb_mode = 1'b1; alu_res_val = 32'h4100_0000;
    push_exp(2'b00, 1'b1, 5'd7, 32'h4100_0000);
    push_exp(2'b00, 1'b1, 5'd8, 32'h4100_0000);
    cmd_src1 = 5'd3; cmd_src2 = 5'd4; cmd_dst = 5'd7; cmd_op = 3'd1;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cmd_src1 = 5'd7; cmd_src2 = 5'd4; cmd_dst = 5'd8; cmd_op = 3'd2;
    ready_seen = 0;
    repeat (4) begin
      @(negedge clk);
      ready_seen += int'(cmd_ready);
    end
    check_output("b2b_no_ready_c1_c4", ready_seen, 32'd0);
    @(negedge clk);
    check_output("b2b_c5_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_output("b2b_cmd2_addr1", {27'b0, mem_rd_addr1}, 32'd7);
    @(negedge clk);
    @(negedge clk);
    check_output("b2b_cmd2_alu_a", alu_a, 32'h4100_0000);
    check_output("b2b_cmd2_alu_b", alu_b, 32'h4000_0000);
    repeat (2) @(negedge clk);
    check_output("b2b_mem8", mem[8], 32'h4100_0000);

    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
